shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Iterative right-shift unit for the CPU datapath, the counterpart of the combinational left shifter. It shifts a 32-bit operand right by one bit per clock, logical or arithmetic, and clamps the shift amount to `N`. The result is returned in the same 36-bit `{N, Z, C, V, result}` flag-plus-data bus format. When `enbit` is low the result portion is tri-stated, so the output can share the ALU result bus.

## Interface
- `N`, default 5: maximum shift amount; any request above `N` shifts by exactly `N`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request a shift; sampled only in IDLE.
- `din` input, 32 bits: operand, captured on the accepting edge.
- `s_value` input, 5 bits: requested shift amount, captured on the accepting edge.
- `arith` input, 1 bit: 1 selects arithmetic (sign-fill), 0 selects logical (zero-fill); captured on the accepting edge.
- `enbit` input, 1 bit: bus output enable.
- `out` output, 36 bits: `{isNegative, isZero, hasCarry, hasOverflow, result[31:0]}` when `enbit=1`; `{4'b0, 32'bz}` when `enbit=0`.
- `busy` output, 1 bit: high in SHIFT and DONE.
- `done` output, 1 bit: one-cycle pulse in DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with `start=1`:
  - capture `din` into the working register;
  - set `k = min(s_value, N)`;
  - capture the fill bit (`arith ? din[31] : 0`);
  - clear the carry bit;
  - go to SHIFT if `k>0`, else to DONE.
- SHIFT, each edge:
  - `work <= {fill, work[31:1]}`;
  - `carry <= work[0]`;
  - `k <= k-1`;
  - go to DONE on the edge where `k` reaches 0.
- DONE: load the result register and flag register from `work`/`carry`, assert `done`, then go to IDLE on the next edge.
- Flags, computed from the final result:
  - N = `result[31]`;
  - Z = (`result == 0`);
  - C = last bit shifted out, or 0 when `k=0`;
  - V = 0 always.
- `out` reflects only the result/flag registers. It holds the previous result throughout SHIFT and does not show intermediate values.
- `start` while `busy=1` is ignored; there is no queuing.
- `enbit` is purely combinational on the output and has no effect on the state machine.

## Timing
- Reset values:
  - state IDLE;
  - `busy=0`, `done=0`;
  - result, flag, working and count registers all 0;
  - `out = 36'h0` when `enbit=1`.
- Latency: `done` is high during the cycle following edge `k+1`, counting the `start`-sampling edge as edge 0.
  - `k=0` gives 1 edge.
  - `k=N=5` gives 6 edges.
- Visibility: the new result and flags appear on `out` in the same cycle that `done` is high, and persist until the next DONE.
- `busy` rises on the edge after `start` is accepted and falls on the edge leaving DONE. Back-to-back operation is possible: `start` may be asserted in the first IDLE cycle after DONE.
- Reset asserted mid-SHIFT: all state clears immediately and asynchronously; no `done` is generated for the aborted operation.
- `s_value` above `N` (up to 31) clamps to `N`; the count never wraps.

## Configuration
- Macro: `SHIFT_RIGHT_SEQ_ARITH_EN`.
- Defined: the `arith` input selects sign-fill.
- Undefined: the fill bit is constant 0 and `arith` is ignored (logical shift only). The port remains present, so instantiations do not change.

## Structure
- Shared ALU package contents:
  - flag bit positions within `out`: N=35, Z=34, C=33, V=32;
  - state enum `{IDLE, SHIFT, DONE}`;
  - constant width 32 and bus width 36.
- No sub-module: the shift register, counter and FSM together form a single module.
- The `out` tri-state mux stays in this module, consistent with the left shifter.

## Test plan
- Logical shift, carry set: `din=0x0000000C`, `s_value=3`, `arith=0` → after 4 edges `done=1`, `out={0,0,1,0,0x00000001}`.
- Arithmetic shift, clamp: `din=0xFFFFFFFF`, `s_value=31`, `arith=1`, `N=5` → `done` after 6 edges, result `0xFFFFFFFF`, N=1, C=1. Same stimulus with `arith=0` → result `0x07FFFFFF`, N=0, C=1. With the macro undefined, both cases → `0x07FFFFFF`.
- Zero result and zero shift: `din=0x10`, `s=5`, logical → result 0, Z=1, C=1. Then `din=0x80000000`, `s=0` → `done` after 1 edge, result `0x80000000`, N=1, C=0.
- Busy and hold: `start` pulsed again mid-SHIFT with a different `din` → ignored, and the first result is delivered. `out` holds the previous result until `done`.
- Bus enable: `enbit=0` at any time → `out[35:32]=0`, `out[31:0]=z`. Raising `enbit` shows the stored result unchanged.
- Reset mid-shift: assert `rst` at edge 2 of a 5-bit shift → `busy=0` immediately, `out=0`, no `done` pulse. A new `start` after release completes normally.

Source files
------------

// File: rtl/shift_right_seq_pkg.sv
// ============================================================================
// Module      : shift_right_seq_pkg
// Description : Shared ALU constants (data/bus widths, flag positions) and
//               the shifter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_right_seq_pkg;

    localparam int c_WIDTH = 32;
    localparam int c_BUS_W = 36;
    localparam int c_CNT_W = 5;

    // Flag bit positions within the 36-bit result bus
    localparam int c_FLAG_N = 35;
    localparam int c_FLAG_Z = 34;
    localparam int c_FLAG_C = 33;
    localparam int c_FLAG_V = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_right_seq_pkg

`default_nettype wire

// File: rtl/shift_right_seq.sv
// ============================================================================
// Module      : shift_right_seq
// Description : Iterative right shifter, one bit per clock, with the shift
//               amount clamped to N. Result is returned on a tri-statable
//               {N,Z,C,V,result} bus. Define SHIFT_RIGHT_SEQ_ARITH_EN to let
//               the arith input select sign-fill; otherwise logical only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int N = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [c_WIDTH-1:0]  din,
    input  logic [c_CNT_W-1:0]  s_value,
    input  logic                arith,
    input  logic                enbit,
    output wire logic [c_BUS_W-1:0] out,
    output logic                busy,
    output logic                done
);

    localparam logic [c_CNT_W-1:0] c_K_MAX = c_CNT_W'(N);
    localparam int c_FLAG_W = c_BUS_W - c_WIDTH;

    state_t                r_state;
    logic [c_WIDTH-1:0]    r_work;
    logic [c_CNT_W-1:0]    r_k;
    logic                  r_fill;
    logic                  r_carry;
    logic [c_WIDTH-1:0]    r_result;
    logic [c_FLAG_W-1:0]   r_flags;
    logic                  r_busy;
    logic                  r_done;

    logic [c_CNT_W-1:0]    w_k_init;
    logic                  w_fill;
    logic [c_FLAG_W-1:0]   w_flags_next;

    assign w_k_init = (s_value > c_K_MAX) ? c_K_MAX : s_value;

`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
    assign w_fill = arith & din[c_WIDTH-1];
`else
    // arith stays on the port so instantiations are build-independent
    assign w_fill = 1'b0 & arith;
`endif

    always_comb begin
        w_flags_next = '0;
        w_flags_next[c_FLAG_N - c_WIDTH] = r_work[c_WIDTH-1];
        w_flags_next[c_FLAG_Z - c_WIDTH] = (r_work == '0);
        w_flags_next[c_FLAG_C - c_WIDTH] = r_carry;
        w_flags_next[c_FLAG_V - c_WIDTH] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_k      <= '0;
            r_fill   <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work  <= din;
                        r_k     <= w_k_init;
                        r_fill  <= w_fill;
                        r_carry <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (w_k_init != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    r_work  <= {r_fill, r_work[c_WIDTH-1:1]};
                    r_carry <= r_work[0];
                    r_k     <= r_k - 1'b1;
                    if (r_k == c_CNT_W'(1))
                        r_state <= DONE;
                end
                DONE: begin
                    // Result bus only changes here, so SHIFT never exposes partial values
                    r_result <= r_work;
                    r_flags  <= w_flags_next;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = enbit ? {r_flags, r_result} : {{c_FLAG_W{1'b0}}, {c_WIDTH{1'bz}}};

endmodule : shift_right_seq

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// ============================================================================
// Module      : tb_shift_right_seq
// Description : Directed self-checking bench for shift_right_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_right_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] din;
    logic [4:0]  s_value;
    logic        arith;
    logic        enbit;
    wire  [35:0] out;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;

    shift_right_seq #(.N(5)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .s_value (s_value),
        .arith   (arith),
        .enbit   (enbit),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request so it is sampled on the next rising edge (edge 0)
    task automatic start_op(input logic [31:0] d, input logic [4:0] s, input logic a);
        @(negedge clk);
        din     = d;
        s_value = s;
        arith   = a;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges until done is seen high; -1 if the budget expires
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; din = '0; s_value = '0; arith = 1'b0; enbit = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (out !== 36'h0) begin n_err++; $display("FAIL reset_out got=%h exp=0", out); end
        rst = 1'b0;
    endtask

    task automatic test_logical();
        int e;
        start_op(32'h0000_000C, 5'd3, 1'b0);
        wait_done(e);
        n_cmp++; if (e !== 4) begin n_err++; $display("FAIL logical_latency got=%0d exp=4", e); end
        n_cmp++; if (out !== {4'b0010, 32'h0000_0001}) begin n_err++; $display("FAIL logical_out got=%h exp=%h", out, {4'b0010, 32'h0000_0001}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL logical_busy_in_done got=%b exp=0", busy); end
    endtask

    task automatic test_clamp();
        int e;
        logic [35:0] exp_a;
        start_op(32'hFFFF_FFFF, 5'd31, 1'b1);
        wait_done(e);
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
        exp_a = {4'b1010, 32'hFFFF_FFFF};
`else
        exp_a = {4'b0010, 32'h07FF_FFFF};
`endif
        n_cmp++; if (e !== 6) begin n_err++; $display("FAIL clamp_arith_latency got=%0d exp=6", e); end
        n_cmp++; if (out !== exp_a) begin n_err++; $display("FAIL clamp_arith_out got=%h exp=%h", out, exp_a); end
        start_op(32'hFFFF_FFFF, 5'd31, 1'b0);
        wait_done(e);
        n_cmp++; if (e !== 6) begin n_err++; $display("FAIL clamp_logic_latency got=%0d exp=6", e); end
        n_cmp++; if (out !== {4'b0010, 32'h07FF_FFFF}) begin n_err++; $display("FAIL clamp_logic_out got=%h exp=%h", out, {4'b0010, 32'h07FF_FFFF}); end
    endtask

    task automatic test_zero();
        int e;
        start_op(32'h0000_0010, 5'd5, 1'b0);
        wait_done(e);
        n_cmp++; if (e !== 6) begin n_err++; $display("FAIL zero_res_latency got=%0d exp=6", e); end
        n_cmp++; if (out !== {4'b0110, 32'h0}) begin n_err++; $display("FAIL zero_res_out got=%h exp=%h", out, {4'b0110, 32'h0}); end
        start_op(32'h8000_0000, 5'd0, 1'b0);
        wait_done(e);
        n_cmp++; if (e !== 1) begin n_err++; $display("FAIL zero_shift_latency got=%0d exp=1", e); end
        n_cmp++; if (out !== {4'b1000, 32'h8000_0000}) begin n_err++; $display("FAIL zero_shift_out got=%h exp=%h", out, {4'b1000, 32'h8000_0000}); end
    endtask

    task automatic test_busy_hold();
        int e;
        start_op(32'h0000_F000, 5'd4, 1'b0);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy got=%b exp=1", busy); end
        n_cmp++; if (out !== {4'b1000, 32'h8000_0000}) begin n_err++; $display("FAIL hold_prev_out got=%h exp=%h", out, {4'b1000, 32'h8000_0000}); end
        din = 32'hFFFF_FFFF; s_value = 5'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(e);
        n_cmp++; if (e !== 4) begin n_err++; $display("FAIL hold_latency got=%0d exp=4", e); end
        n_cmp++; if (out !== {4'b0000, 32'h0000_0F00}) begin n_err++; $display("FAIL hold_result got=%h exp=%h", out, {4'b0000, 32'h0000_0F00}); end
    endtask

    task automatic test_back_to_back();
        int e;
        // Issue the next request in the cycle where done is still high
        din = 32'h0000_0003; s_value = 5'd1; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(e);
        n_cmp++; if (e !== 2) begin n_err++; $display("FAIL b2b_latency got=%0d exp=2", e); end
        n_cmp++; if (out !== {4'b0010, 32'h0000_0001}) begin n_err++; $display("FAIL b2b_out got=%h exp=%h", out, {4'b0010, 32'h0000_0001}); end
    endtask

    task automatic test_bus_enable();
        int e;
        logic [31:0] data;
        @(negedge clk);
        enbit = 1'b0;
        #1;
        data = out[31:0];
        n_cmp++; if (out[35:32] !== 4'b0) begin n_err++; $display("FAIL bus_off_flags got=%b exp=0000", out[35:32]); end
        n_cmp++; if (data !== 32'bz && data !== 32'h0) begin n_err++; $display("FAIL bus_off_data got=%h exp=zzzzzzzz", data); end
        start_op(32'h0000_0100, 5'd2, 1'b0);
        wait_done(e);
        n_cmp++; if (e !== 3) begin n_err++; $display("FAIL bus_off_latency got=%0d exp=3", e); end
        enbit = 1'b1;
        #1;
        n_cmp++; if (out !== {4'b0000, 32'h0000_0040}) begin n_err++; $display("FAIL bus_on_out got=%h exp=%h", out, {4'b0000, 32'h0000_0040}); end
    endtask

    task automatic test_reset_mid();
        int e;
        int pulses;
        start_op(32'hFFFF_0000, 5'd5, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_cmp++; if (out !== 36'h0) begin n_err++; $display("FAIL rstmid_out got=%h exp=0", out); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_no_done got=%0d exp=0", pulses); end
        start_op(32'h0000_0020, 5'd5, 1'b0);
        wait_done(e);
        n_cmp++; if (e !== 6) begin n_err++; $display("FAIL rstmid_restart_latency got=%0d exp=6", e); end
        n_cmp++; if (out !== {4'b0000, 32'h0000_0001}) begin n_err++; $display("FAIL rstmid_restart_out got=%h exp=%h", out, {4'b0000, 32'h0000_0001}); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_logical();
        test_clamp();
        test_zero();
        test_busy_hold();
        test_back_to_back();
        test_bus_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_shift_right_seq

`default_nettype wire
